// File: rtl/cmdin_stream_monitor_pkg.sv
// Shared command-in constants, monitor error codes and parser states.
package cmdin_stream_monitor_pkg;

    // Header word layout
    localparam int CMD_TYPE_L      = 0;
    localparam int CMD_TYPE_H      = 7;
    localparam int NUM_ARGS_OFFSET = 8;
    localparam int DESTID_L        = 32;
    localparam int DESTID_H        = 39;

    localparam logic [7:0] HWR_CMDOUT_ID_BYTE = 8'h11;

    // TID word: non-zero top byte marks an accelerator-originated task
    localparam int ACC_TASK_L = 56;

    // Argument flag word carries the argument index in its upper half
    localparam int ARG_FLAG_IDX_L = 32;

    localparam logic [7:0] EXEC_TASK_CODE      = 8'h01;
    localparam logic [7:0] SETUP_HW_INST_CODE  = 8'h02;
    localparam logic [7:0] EXEC_PERI_TASK_CODE = 8'h05;

    typedef enum logic [3:0] {
        ErrNone        = 4'd0,
        ErrBadType     = 4'd1,
        ErrBadDestid   = 4'd2,
        ErrTooManyArgs = 4'd3,
        ErrDestRange   = 4'd4,
        ErrDestChange  = 4'd5,
        ErrAccNotExec  = 4'd6,
        ErrAccNoargs   = 4'd7,
        ErrArgIdx      = 4'd8,
        ErrEarlyLast   = 4'd9,
        ErrMissingLast = 4'd10
    } CmdinMonErr_t;

    typedef enum logic [2:0] {
        StHeader,
        StTid,
        StPtid,
        StPeriod,
        StArgFlag,
        StArg,
        StDrain
    } cmdin_mon_state_e;

    function automatic logic is_known_code(input logic [7:0] code);
        return (code == EXEC_TASK_CODE) || (code == SETUP_HW_INST_CODE) ||
               (code == EXEC_PERI_TASK_CODE);
    endfunction

endpackage

// File: rtl/cmdin_mon_stats.sv
// Per-accelerator saturating command counters with a registered read port.
module cmdin_mon_stats
    import cmdin_stream_monitor_pkg::*;
#(
    parameter int NUM_ACCS = 16,
    parameter int CNT_W    = 32,
    parameter int ACC_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic [ACC_ID_W-1:0] inc_sel_i,
    input  logic                clear_i,
    input  logic [ACC_ID_W-1:0] rd_sel_i,
    output logic [CNT_W-1:0]    rd_data_o
);

    logic [CNT_W-1:0] cnt_q [NUM_ACCS];
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] rd_data_q;

    for (genvar i = 0; i < NUM_ACCS; i++) begin : g_cnt
        // Saturating increment; clear overrides a coincident increment
        always_ff @(posedge clk) begin
            if (rst || clear_i) begin
                cnt_q[i] <= '0;
            end else if (inc_i && (inc_sel_i == ACC_ID_W'(i)) && (cnt_q[i] != '1)) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // Read select; out-of-range selects read as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_ACCS; i++) begin
            if (rd_sel_i == ACC_ID_W'(i)) rd_mux = cnt_q[i];
        end
    end

    // Registered read port, zeroed together with the bank
    always_ff @(posedge clk) begin
        if (rst || clear_i) rd_data_q <= '0;
        else                rd_data_q <= rd_mux;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cmdin_stream_monitor.sv
// Passive command-in AXI-Stream parser: latches the first violation, resyncs on
// packet boundaries and counts good commands and violating packets.
module cmdin_stream_monitor
    import cmdin_stream_monitor_pkg::*;
#(
    parameter int NUM_ACCS = 16,
    parameter int MAX_ARGS = 15,
    parameter int CNT_W    = 32,
    localparam int ACC_ID_W = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    input  logic                s_ready,
    input  logic [63:0]         s_data,
    input  logic                s_last,
    input  logic [7:0]          s_dest,
    input  logic                clear_err,
    input  logic                clear_stats,
    output logic                err_valid,
    output logic [3:0]          err_code,
    output logic [7:0]          err_dest,
    output logic [7:0]          err_word,
    output logic [63:0]         err_data,
    output logic                busy,
    input  logic [ACC_ID_W-1:0] stat_sel,
    output logic [CNT_W-1:0]    stat_cmds,
    output logic [CNT_W-1:0]    total_cmds,
    output logic [CNT_W-1:0]    total_errs
);

    cmdin_mon_state_e state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  nargs_q, nargs_d;
    logic [7:0]  dest_q, dest_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  word_q, word_d;
    logic        pkt_err_q, pkt_err_d;

    logic        err_valid_q;
    logic [3:0]  err_code_q;
    logic [7:0]  err_dest_q, err_word_q;
    logic [63:0] err_data_q;
    logic [CNT_W-1:0] total_cmds_q, total_errs_q;

    logic         beat, final_w, pkt_end, good_pkt, err_inc, any_hit, acc_task;
    logic [10:1]  hits;
    CmdinMonErr_t first_err;

    logic [7:0] hdr_code, hdr_nargs;
    assign beat      = s_valid && s_ready;
    assign hdr_code  = s_data[CMD_TYPE_H:CMD_TYPE_L];
    assign hdr_nargs = s_data[NUM_ARGS_OFFSET +: 8];
    assign acc_task  = s_data[63:ACC_TASK_L] != '0;

    // Next-state parse of the current beat and per-beat violation detection
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        nargs_d   = nargs_q;
        dest_d    = dest_q;
        idx_d     = idx_q;
        word_d    = word_q;
        pkt_err_d = pkt_err_q;
        hits      = '0;
        final_w   = 1'b0;
        pkt_end   = 1'b0;
        if (beat) begin
            unique case (state_q)
                StHeader: begin
                    code_d   = hdr_code;
                    nargs_d  = hdr_nargs;
                    dest_d   = s_dest;
                    idx_d    = '0;
                    hits[1]  = !is_known_code(hdr_code);
                    hits[2]  = (hdr_code != SETUP_HW_INST_CODE) &&
                               (s_data[DESTID_H:DESTID_L] != HWR_CMDOUT_ID_BYTE);
                    hits[3]  = hdr_nargs > 8'(MAX_ARGS);
                    hits[4]  = {1'b0, s_dest} >= 9'(NUM_ACCS);
                    state_d  = StTid;
                end
                StTid: begin
                    hits[6] = acc_task && (code_q != EXEC_TASK_CODE);
                    hits[7] = acc_task && (nargs_q == '0);
                    final_w = code_q == SETUP_HW_INST_CODE;
                    state_d = StPtid;
                end
                StPtid: begin
                    if (code_q == EXEC_PERI_TASK_CODE) state_d = StPeriod;
                    else if (nargs_q != '0)           state_d = StArgFlag;
                    else                              final_w = 1'b1;
                end
                StPeriod: begin
                    if (nargs_q != '0) state_d = StArgFlag;
                    else               final_w = 1'b1;
                end
                StArgFlag: begin
                    hits[8] = s_data[63:ARG_FLAG_IDX_L] != {24'h0, idx_q};
                    state_d = StArg;
                end
                StArg: begin
                    idx_d = idx_q + 8'd1;
                    if (idx_d == nargs_q) final_w = 1'b1;
                    else                  state_d = StArgFlag;
                end
                StDrain: begin
                    if (s_last) begin
                        pkt_end = 1'b1;
                        state_d = StHeader;
                    end
                end
                default: state_d = StHeader;
            endcase

            if (state_q != StDrain) begin
                if (state_q != StHeader) hits[5] = s_dest != dest_q;
                hits[9]  = s_last && !final_w;
                hits[10] = !s_last && final_w;
                if (s_last) begin
                    // Either the packet completed or it ended early; both resync here
                    pkt_end = 1'b1;
                    state_d = StHeader;
                end else if (hits[10]) begin
                    state_d = StDrain;
                end else if ((state_q == StHeader) && (hits[1] || hits[3])) begin
                    // Header cannot be trusted to frame the packet; skip to last
                    state_d = StDrain;
                end
            end

            word_d = pkt_end ? 8'd0 : word_q + 8'd1;
        end

        any_hit = |hits;
        if (any_hit) pkt_err_d = 1'b1;
        if (pkt_end) pkt_err_d = 1'b0;
        good_pkt = pkt_end && !pkt_err_q && !any_hit;
        err_inc  = any_hit && !pkt_err_q;

        first_err = ErrNone;
        for (int i = 10; i >= 1; i--) begin
            if (hits[i]) first_err = CmdinMonErr_t'(4'(i));
        end
    end

    // Parser state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StHeader;
            code_q    <= '0;
            nargs_q   <= '0;
            dest_q    <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            pkt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            nargs_q   <= nargs_d;
            dest_q    <= dest_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            pkt_err_q <= pkt_err_d;
        end
    end

    // Sticky first-error capture; a new error beats a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_dest_q  <= '0;
            err_word_q  <= '0;
            err_data_q  <= '0;
        end else if (any_hit && (!err_valid_q || clear_err)) begin
            err_valid_q <= 1'b1;
            err_code_q  <= first_err;
            err_dest_q  <= s_dest;
            err_word_q  <= word_q;
            err_data_q  <= s_data;
        end else if (clear_err) begin
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_dest_q  <= '0;
            err_word_q  <= '0;
            err_data_q  <= '0;
        end
    end

    // Saturating totals; clear overrides a coincident increment
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            total_cmds_q <= '0;
            total_errs_q <= '0;
        end else begin
            if (good_pkt && (total_cmds_q != '1)) total_cmds_q <= total_cmds_q + 1'b1;
            if (err_inc && (total_errs_q != '1))  total_errs_q <= total_errs_q + 1'b1;
        end
    end

    cmdin_mon_stats #(
        .NUM_ACCS (NUM_ACCS),
        .CNT_W    (CNT_W),
        .ACC_ID_W (ACC_ID_W)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (good_pkt),
        .inc_sel_i (dest_q[ACC_ID_W-1:0]),
        .clear_i   (clear_stats),
        .rd_sel_i  (stat_sel),
        .rd_data_o (stat_cmds)
    );

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_dest   = err_dest_q;
    assign err_word   = err_word_q;
    assign err_data   = err_data_q;
    assign busy       = state_q != StHeader;
    assign total_cmds = total_cmds_q;
    assign total_errs = total_errs_q;

endmodule

// File: tb/tb_cmdin_stream_monitor.sv
// Directed bench for cmdin_stream_monitor (small counters to reach saturation).
module tb_cmdin_stream_monitor;

    localparam int NUM_ACCS = 16;
    localparam int MAX_ARGS = 15;
    localparam int CNT_W    = 4;
    localparam int ACC_ID_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_valid = 1'b0, s_ready = 1'b0, s_last = 1'b0;
    logic [63:0]         s_data = '0;
    logic [7:0]          s_dest = '0;
    logic                clear_err = 1'b0, clear_stats = 1'b0;
    logic                err_valid, busy;
    logic [3:0]          err_code;
    logic [7:0]          err_dest, err_word;
    logic [63:0]         err_data;
    logic [ACC_ID_W-1:0] stat_sel = '0;
    logic [CNT_W-1:0]    stat_cmds, total_cmds, total_errs;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cmdin_stream_monitor #(
        .NUM_ACCS (NUM_ACCS),
        .MAX_ARGS (MAX_ARGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_dest      (s_dest),
        .clear_err   (clear_err),
        .clear_stats (clear_stats),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .err_dest    (err_dest),
        .err_word    (err_word),
        .err_data    (err_data),
        .busy        (busy),
        .stat_sel    (stat_sel),
        .stat_cmds   (stat_cmds),
        .total_cmds  (total_cmds),
        .total_errs  (total_errs)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic l, input logic [7:0] dst);
        s_valid = 1'b1;
        s_ready = 1'b1;
        s_data  = d;
        s_last  = l;
        s_dest  = dst;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] code, input logic [7:0] nargs);
        logic [63:0] d;
        d        = '0;
        d[7:0]   = code;
        d[15:8]  = nargs;
        d[39:32] = 8'h11;
        return d;
    endfunction

    function automatic logic [63:0] aflag(input int idx);
        return {32'(idx), 32'h0000_0003};
    endfunction

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_err_data", err_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_total_cmds", 64'(total_cmds), 64'd0);
        chk("rst_total_errs", 64'(total_errs), 64'd0);
        chk("rst_stat_cmds", 64'(stat_cmds), 64'd0);

        // Reset in the middle of a packet
        beat(hdr(8'h01, 8'd0), 1'b0, 8'd3);
        chk("midpkt_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midpkt_rst_busy", 64'(busy), 64'd0);

        // EXEC_TASK, 2 args, with a stalled cycle mid-packet
        stat_sel = 4'd3;
        beat(hdr(8'h01, 8'd2), 1'b0, 8'd3);
        beat(64'h0000_0000_0000_1234, 1'b0, 8'd3);
        beat(64'h0, 1'b0, 8'd3);
        beat(aflag(0), 1'b0, 8'd3);
        s_valid = 1'b1; s_ready = 1'b0; s_last = 1'b1; s_data = 64'hDEAD;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        beat(64'hAAAA, 1'b0, 8'd3);
        beat(aflag(1), 1'b0, 8'd3);
        beat(64'hBBBB, 1'b1, 8'd3);
        chk("exec_total_cmds", 64'(total_cmds), 64'd1);
        chk("exec_err_valid", 64'(err_valid), 64'd0);
        chk("exec_busy", 64'(busy), 64'd0);
        tick();
        chk("exec_stat3", 64'(stat_cmds), 64'd1);

        // EXEC_PERI nArgs=0 back-to-back with SETUP
        beat(hdr(8'h05, 8'd0), 1'b0, 8'd5);
        beat(64'h0, 1'b0, 8'd5);
        beat(64'h0, 1'b0, 8'd5);
        beat(64'h10, 1'b1, 8'd5);
        beat(hdr(8'h02, 8'd0), 1'b0, 8'd5);
        beat(64'h0, 1'b1, 8'd5);
        chk("peri_setup_total_cmds", 64'(total_cmds), 64'd3);
        chk("peri_setup_busy", 64'(busy), 64'd0);
        chk("peri_setup_err_valid", 64'(err_valid), 64'd0);

        // Early last on the 5th beat
        beat(hdr(8'h01, 8'd2), 1'b0, 8'd3);
        beat(64'h0, 1'b0, 8'd3);
        beat(64'h0, 1'b0, 8'd3);
        beat(aflag(0), 1'b0, 8'd3);
        beat(64'hA5A5, 1'b1, 8'd3);
        chk("early_err_valid", 64'(err_valid), 64'd1);
        chk("early_err_code", 64'(err_code), 64'd9);
        chk("early_err_word", 64'(err_word), 64'd4);
        chk("early_err_dest", 64'(err_dest), 64'd3);
        chk("early_err_data", err_data, 64'hA5A5);
        chk("early_total_errs", 64'(total_errs), 64'd1);
        chk("early_busy", 64'(busy), 64'd0);
        beat(hdr(8'h01, 8'd0), 1'b0, 8'd3);
        beat(64'h0, 1'b0, 8'd3);
        beat(64'h0, 1'b1, 8'd3);
        chk("early_next_total_cmds", 64'(total_cmds), 64'd4);
        chk("early_sticky_code", 64'(err_code), 64'd9);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("clear_err_valid", 64'(err_valid), 64'd0);

        // Missing last, then DRAIN absorbs junk
        beat(hdr(8'h01, 8'd1), 1'b0, 8'd3);
        beat(64'h0, 1'b0, 8'd3);
        beat(64'h0, 1'b0, 8'd3);
        beat(aflag(0), 1'b0, 8'd3);
        beat(64'hC0DE, 1'b0, 8'd3);
        chk("missing_err_code", 64'(err_code), 64'd10);
        chk("missing_err_word", 64'(err_word), 64'd4);
        chk("missing_busy", 64'(busy), 64'd1);
        beat(hdr(8'h01, 8'd0), 1'b0, 8'd7);
        beat(64'h1, 1'b0, 8'd7);
        chk("drain_busy", 64'(busy), 64'd1);
        beat(64'h2, 1'b1, 8'd7);
        chk("drain_done_busy", 64'(busy), 64'd0);
        chk("missing_total_errs", 64'(total_errs), 64'd2);
        beat(hdr(8'h02, 8'd0), 1'b0, 8'd2);
        beat(64'h0, 1'b1, 8'd2);
        chk("after_drain_total_cmds", 64'(total_cmds), 64'd5);
        chk("after_drain_code", 64'(err_code), 64'd10);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;

        // DEST_RANGE beats ACC_NOT_EXEC; one count per packet
        beat(hdr(8'h05, 8'd1), 1'b0, 8'd16);
        chk("range_err_code", 64'(err_code), 64'd4);
        chk("range_err_dest", 64'(err_dest), 64'h10);
        chk("range_err_word", 64'(err_word), 64'd0);
        chk("range_total_errs", 64'(total_errs), 64'd3);
        beat(64'h0100_0000_0000_0000, 1'b0, 8'd16);
        beat(64'h0, 1'b0, 8'd16);
        beat(64'h0, 1'b0, 8'd16);
        beat(aflag(0), 1'b0, 8'd16);
        beat(64'h9, 1'b1, 8'd16);
        chk("range_code_kept", 64'(err_code), 64'd4);
        chk("range_total_errs_once", 64'(total_errs), 64'd3);
        chk("range_total_cmds", 64'(total_cmds), 64'd5);
        beat(hdr(8'h7F, 8'd0), 1'b1, 8'd1);
        chk("second_err_code", 64'(err_code), 64'd4);
        chk("second_total_errs", 64'(total_errs), 64'd4);
        chk("second_busy", 64'(busy), 64'd0);

        // New error coincident with clear_err; TOO_MANY_ARGS drains
        clear_err = 1'b1;
        beat(hdr(8'h01, 8'(MAX_ARGS + 1)), 1'b0, 8'd1);
        clear_err = 1'b0;
        chk("clrnew_err_valid", 64'(err_valid), 64'd1);
        chk("clrnew_err_code", 64'(err_code), 64'd3);
        chk("clrnew_total_errs", 64'(total_errs), 64'd5);
        chk("toomany_busy", 64'(busy), 64'd1);
        beat(64'h0, 1'b1, 8'd1);
        chk("toomany_drain_busy", 64'(busy), 64'd0);

        // nArgs == MAX_ARGS is legal
        beat(hdr(8'h01, 8'(MAX_ARGS)), 1'b0, 8'd1);
        beat(64'h0, 1'b0, 8'd1);
        beat(64'h0, 1'b0, 8'd1);
        for (int i = 0; i < MAX_ARGS; i++) begin
            beat(aflag(i), 1'b0, 8'd1);
            beat(64'(i), (i == MAX_ARGS - 1), 8'd1);
        end
        chk("maxargs_total_cmds", 64'(total_cmds), 64'd6);
        chk("maxargs_total_errs", 64'(total_errs), 64'd5);
        chk("maxargs_code_kept", 64'(err_code), 64'd3);

        // Wrong argument index on the flag word
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        beat(hdr(8'h01, 8'd1), 1'b0, 8'd4);
        beat(64'h0, 1'b0, 8'd4);
        beat(64'h0, 1'b0, 8'd4);
        beat(aflag(7), 1'b0, 8'd4);
        beat(64'h0, 1'b1, 8'd4);
        chk("argidx_err_code", 64'(err_code), 64'd8);
        chk("argidx_err_word", 64'(err_word), 64'd3);
        chk("argidx_total_errs", 64'(total_errs), 64'd6);

        // Saturation of stat_cmds[0] and total_cmds (4-bit counters)
        stat_sel = 4'd0;
        for (int i = 0; i < 15; i++) begin
            beat(hdr(8'h02, 8'd0), 1'b0, 8'd0);
            beat(64'h0, 1'b1, 8'd0);
        end
        tick();
        chk("sat_stat0", 64'(stat_cmds), 64'hF);
        chk("sat_total_cmds", 64'(total_cmds), 64'hF);
        beat(hdr(8'h02, 8'd0), 1'b0, 8'd0);
        beat(64'h0, 1'b1, 8'd0);
        tick();
        chk("sat_hold_stat0", 64'(stat_cmds), 64'hF);
        chk("sat_hold_total_cmds", 64'(total_cmds), 64'hF);

        // clear_stats wins over a completing packet
        beat(hdr(8'h02, 8'd0), 1'b0, 8'd0);
        clear_stats = 1'b1;
        beat(64'h0, 1'b1, 8'd0);
        clear_stats = 1'b0;
        chk("clr_total_cmds", 64'(total_cmds), 64'd0);
        chk("clr_total_errs", 64'(total_errs), 64'd0);
        tick();
        chk("clr_stat0", 64'(stat_cmds), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
